pwm_decoder: RTL

- Recovers the duty value from a single-bit PWM waveform and reports it as a 32-bit width plus the measured period.
- Acts as the receiving end of the PWM sine path: the PWM output of the sine generator is looped back into this block.
- The bench can confirm that each reported width equals the width that was programmed.
- On silicon, it recovers the modulating value from an external PWM pin.

---
 rtl/pwm_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// PWM duty/period recovery: synchronizes pwm_in, measures high and total cycles per period,
// and reports on each rising edge or on MAX_PERIOD timeout. Optional glitch filter: PWM_DECODE_FILTER_EN.
module pwm_decoder #(
  parameter int unsigned MAX_PERIOD = 1000,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pwm_in,
  output logic [31:0] width,
  output logic [31:0] period,
  output logic        valid,
  output logic        timeout
);

  if (MAX_PERIOD < 2 || FILTER_LEN < 2) begin : g_bad_cfg
    $error("pwm_decoder: MAX_PERIOD and FILTER_LEN must both be at least 2");
  end

  localparam logic [31:0] MAXP = 32'(MAX_PERIOD);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t      state, state_n;
  logic        sync1, sync2, s, s_d, rise;
  logic [31:0] tcnt, hcnt, lcnt, sum;
  logic [31:0] tcnt_n, hcnt_n, lcnt_n;
  logic [31:0] rep_width, rep_period;
  logic        rep_valid, rep_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DECODE_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);

  logic [FW-1:0] fcnt;
  logic          s_f;

  // Level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
      s_f  <= 1'b0;
    end else if (sync2 == s_f) begin
      fcnt <= '0;
    end else if (fcnt == FLAST) begin
      s_f  <= sync2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  assign s = s_f;
`else
  assign s = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign rise = s & ~s_d;
  assign sum  = hcnt + lcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    state_n = ARM;
        ARM:     if (rise) state_n = MEAS;
        MEAS:    state_n = MEAS;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    rep_valid   = 1'b0;
    rep_timeout = 1'b0;
    rep_width   = '0;
    rep_period  = '0;
    tcnt_n      = tcnt;
    hcnt_n      = hcnt;
    lcnt_n      = lcnt;
    if (!en || state == IDLE) begin
      tcnt_n = '0;
      hcnt_n = '0;
      lcnt_n = '0;
    end else if (state == ARM) begin
      tcnt_n = tcnt + 32'd1;
      if (rise) begin
        tcnt_n = '0;
        hcnt_n = 32'd1;
        lcnt_n = '0;
      end else if (tcnt == MAXP) begin
        rep_valid   = 1'b1;
        rep_timeout = 1'b1;
        rep_width   = s ? MAXP : '0;
        rep_period  = MAXP;
        tcnt_n      = 32'd1;
      end
    end else begin
      // The rise cycle and the timeout cycle both count as the first cycle of the next window.
      if (rise) begin
        rep_valid  = 1'b1;
        rep_width  = hcnt;
        rep_period = sum;
        hcnt_n     = 32'd1;
        lcnt_n     = '0;
      end else if (sum == MAXP) begin
        rep_valid   = 1'b1;
        rep_timeout = 1'b1;
        rep_width   = hcnt;
        rep_period  = MAXP;
        hcnt_n      = {31'b0, s};
        lcnt_n      = {31'b0, ~s};
      end else begin
        hcnt_n = hcnt + {31'b0, s};
        lcnt_n = lcnt + {31'b0, ~s};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      hcnt    <= '0;
      lcnt    <= '0;
      width   <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= tcnt_n;
      hcnt    <= hcnt_n;
      lcnt    <= lcnt_n;
      valid   <= rep_valid;
      timeout <= rep_valid & rep_timeout;
      if (rep_valid) begin
        width  <= rep_width;
        period <= rep_period;
      end
    end
  end

endmodule
